// File: rtl/cpuy_pkg.sv
// Shared cpuy types: interrupt controller state, source indices and default vector map.
// Pure declarations; no logic, no latency.
package cpuy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam int SRC_EXT = 0;
  localparam int SRC_T0  = 1;
  localparam int SRC_T1  = 2;

  localparam int         NUM_SRC_DEF    = 3;
  localparam int         ADDR_W_DEF     = 10;
  localparam logic [9:0] VEC_BASE_DEF   = 10'h010;
  localparam logic [9:0] VEC_STRIDE_DEF = 10'h010;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set index wins. Purely combinational, zero latency,
// no backpressure; o_vld is low and o_idx is zero when nothing is requesting.
module int_prio_enc #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);

  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    // Walk from high to low so the lowest set index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDX_W'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: latch, mask, arbitrate, and run IRQ/ACK/EOI with the core.
// irq is registered (1 cycle after eligibility); the core paces it via irq_ack and eoi, no nesting.
module int_ctrl
  import cpuy_pkg::*;
#(
  parameter int                NUM_SRC    = NUM_SRC_DEF,
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(VEC_BASE_DEF),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(VEC_STRIDE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_req,
  input  logic [NUM_SRC-1:0] src_edge,
  input  logic               gie,
  input  logic [NUM_SRC-1:0] src_ie,
  output logic               irq,
  output logic [ADDR_W-1:0]  vector,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic [NUM_SRC-1:0] src_ack,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  state_t               r_state;
  logic [IDX_W-1:0]     r_cur_src;
  logic                 r_irq;
  logic [ADDR_W-1:0]    r_vector;
  logic [NUM_SRC-1:0]   r_src_ack;
  logic                 r_in_service;
  logic [NUM_SRC-1:0]   r_prev;
  logic [NUM_SRC-1:0]   r_pending;

  logic [NUM_SRC-1:0]   w_set;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_pend_nxt;
  logic [NUM_SRC-1:0]   w_elig;
  logic [IDX_W-1:0]     w_win_idx;
  logic                 w_win_vld;
  logic                 w_ack_fire;
  logic [ADDR_W-1:0]    w_vec;

  assign w_ack_fire = (r_state == REQUEST) && irq_ack;
  assign w_set      = src_req & ~r_prev;
  assign w_clr      = w_ack_fire ? (NUM_SRC'(1) << r_cur_src) : '0;
  // Edge bits: a fresh edge beats the ack clear. Level bits just mirror the source.
  assign w_pend_nxt = (src_edge & (w_set | (r_pending & ~w_clr))) | (~src_edge & src_req);
  assign w_elig     = r_pending & src_ie & {NUM_SRC{gie}};
  assign w_vec      = VEC_BASE + (ADDR_W'(w_win_idx) * VEC_STRIDE);

  int_prio_enc #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .i_req (w_elig),
    .o_idx (w_win_idx),
    .o_vld (w_win_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= src_req;
      r_pending <= w_pend_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cur_src    <= '0;
      r_irq        <= 1'b0;
      r_vector     <= VEC_BASE;
      r_src_ack    <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_src_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            r_cur_src <= w_win_idx;
            r_vector  <= w_vec;
            r_irq     <= 1'b1;
            r_state   <= REQUEST;
          end
        end
        REQUEST: begin
          // Winner stays locked here; only ack or a mask drop moves us on, ack first.
          if (irq_ack) begin
            r_irq                <= 1'b0;
            r_src_ack[r_cur_src] <= 1'b1;
            r_in_service         <= 1'b1;
            r_state              <= SERVICE;
          end else if (!gie || !src_ie[r_cur_src]) begin
            r_irq   <= 1'b0;
            r_state <= IDLE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            r_in_service <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_irq   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign irq        = r_irq;
  assign vector     = r_vector;
  assign src_ack    = r_src_ack;
  assign in_service = r_in_service;
  assign pending    = r_pending;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reset, edge/level arbitration, withdrawal, collision, spurious pulses.
module tb_int_ctrl;
  import cpuy_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src_req;
  logic [2:0] src_edge;
  logic       gie;
  logic [2:0] src_ie;
  logic       irq;
  logic [9:0] vector;
  logic       irq_ack;
  logic       eoi;
  logic [2:0] src_ack;
  logic       in_service;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .src_req    (src_req),
    .src_edge   (src_edge),
    .gie        (gie),
    .src_ie     (src_ie),
    .irq        (irq),
    .vector     (vector),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .src_ack    (src_ack),
    .in_service (in_service),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; tick(); eoi = 1'b0;
  endtask

  task automatic edge_pulse(input logic [2:0] bits);
    src_req = bits; tick(); src_req = 3'b000;
  endtask

  task automatic test_reset();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
    checks++; if (vector !== 10'h010) begin errors++; $display("FAIL rst_vector got %h exp 010", vector); end
    rst = 1'b0;
    gie = 1'b1; src_ie = 3'b001; src_edge = 3'b111;
    tick();
    edge_pulse(3'b001);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rst_pre_irq got %b exp 1", irq); end
    #2 rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_async_irq got %b exp 0", irq); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL rst_async_insvc got %b exp 0", in_service); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL rst_async_pending got %b exp 000", pending); end
    checks++; if (vector !== 10'h010) begin errors++; $display("FAIL rst_async_vector got %h exp 010", vector); end
    checks++; if (src_ack !== 3'b000) begin errors++; $display("FAIL rst_async_srcack got %b exp 000", src_ack); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_after_irq got %b exp 0", irq); end
  endtask

  task automatic test_single_edge();
    gie = 1'b1; src_ie = 3'b001; src_edge = 3'b111;
    edge_pulse(3'b001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL se_irq_early got %b exp 0", irq); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL se_pending got %b exp 001", pending); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL se_irq got %b exp 1", irq); end
    checks++; if (vector !== 10'h010) begin errors++; $display("FAIL se_vector got %h exp 010", vector); end
    pulse_ack();
    checks++; if (src_ack !== 3'b001) begin errors++; $display("FAIL se_srcack got %b exp 001", src_ack); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL se_insvc got %b exp 1", in_service); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL se_pending_clr got %b exp 000", pending); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL se_irq_drop got %b exp 0", irq); end
    tick();
    checks++; if (src_ack !== 3'b000) begin errors++; $display("FAIL se_srcack_1cyc got %b exp 000", src_ack); end
    pulse_eoi();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL se_eoi_insvc got %b exp 0", in_service); end
    tick();
  endtask

  task automatic test_simultaneous();
    src_ie = 3'b111;
    edge_pulse(3'b110);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sim_irq got %b exp 1", irq); end
    checks++; if (vector !== 10'h020) begin errors++; $display("FAIL sim_vector got %h exp 020", vector); end
    pulse_ack();
    checks++; if (src_ack !== 3'b010) begin errors++; $display("FAIL sim_srcack got %b exp 010", src_ack); end
    checks++; if (pending !== 3'b100) begin errors++; $display("FAIL sim_pending got %b exp 100", pending); end
    tick();
    pulse_eoi();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sim_irq_gap got %b exp 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL sim_irq2 got %b exp 1", irq); end
    checks++; if (vector !== 10'h030) begin errors++; $display("FAIL sim_vector2 got %h exp 030", vector); end
    pulse_ack();
    checks++; if (src_ack !== 3'b100) begin errors++; $display("FAIL sim_srcack2 got %b exp 100", src_ack); end
    pulse_eoi();
    tick();
  endtask

  task automatic test_no_preempt();
    edge_pulse(3'b100);
    tick();
    checks++; if (vector !== 10'h030) begin errors++; $display("FAIL np_vector got %h exp 030", vector); end
    pulse_ack();
    edge_pulse(3'b001);
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL np_irq got %b exp 0", irq); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL np_pending got %b exp 001", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL np_insvc got %b exp 1", in_service); end
    pulse_eoi();
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL np_irq2 got %b exp 1", irq); end
    checks++; if (vector !== 10'h010) begin errors++; $display("FAIL np_vector2 got %h exp 010", vector); end
    pulse_ack();
    pulse_eoi();
    tick();
  endtask

  task automatic test_withdraw();
    edge_pulse(3'b010);
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wd_irq got %b exp 1", irq); end
    gie = 1'b0;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_irq_drop got %b exp 0", irq); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL wd_pending got %b exp 010", pending); end
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_irq_stay got %b exp 0", irq); end
    gie = 1'b1;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wd_irq_back got %b exp 1", irq); end
    checks++; if (vector !== 10'h020) begin errors++; $display("FAIL wd_vector got %h exp 020", vector); end
    src_ie = 3'b101;
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wd_ie_drop got %b exp 0", irq); end
    src_ie = 3'b111;
    tick();
    pulse_ack();
    checks++; if (src_ack !== 3'b010) begin errors++; $display("FAIL wd_srcack got %b exp 010", src_ack); end
    pulse_eoi();
    tick();
  endtask

  task automatic test_collision_spurious();
    edge_pulse(3'b001);
    tick();
    src_req = 3'b001; irq_ack = 1'b1;
    tick();
    src_req = 3'b000; irq_ack = 1'b0;
    checks++; if (src_ack !== 3'b001) begin errors++; $display("FAIL col_srcack got %b exp 001", src_ack); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL col_pending got %b exp 001", pending); end
    pulse_ack();
    checks++; if (src_ack !== 3'b000) begin errors++; $display("FAIL sp_ack_svc got %b exp 000", src_ack); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL sp_ack_insvc got %b exp 1", in_service); end
    pulse_eoi();
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL col_rearm got %b exp 1", irq); end
    pulse_ack();
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL col_pending_clr got %b exp 000", pending); end
    pulse_eoi();
    tick();
    pulse_eoi();
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL sp_eoi_idle got %b exp 0", in_service); end
    pulse_ack();
    checks++; if (src_ack !== 3'b000) begin errors++; $display("FAIL sp_ack_idle got %b exp 000", src_ack); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sp_irq_idle got %b exp 0", irq); end
  endtask

  task automatic test_level_retrigger();
    src_edge = 3'b101;
    src_req  = 3'b010;
    tick();
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL lv_pending got %b exp 010", pending); end
    tick();
    checks++; if (vector !== 10'h020) begin errors++; $display("FAIL lv_vector got %h exp 020", vector); end
    pulse_ack();
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL lv_pending_held got %b exp 010", pending); end
    pulse_eoi();
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lv_retrig got %b exp 1", irq); end
    src_req = 3'b000;
    pulse_ack();
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL lv_pending_low got %b exp 000", pending); end
    pulse_eoi();
    tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lv_quiet got %b exp 0", irq); end
    src_edge = 3'b111;
  endtask

  initial begin
    rst = 1'b1; src_req = 3'b000; src_edge = 3'b000; gie = 1'b0;
    src_ie = 3'b000; irq_ack = 1'b0; eoi = 1'b0;
    #1;
    test_reset();
    test_single_edge();
    test_simultaneous();
    test_no_preempt();
    test_withdraw();
    test_collision_spurious();
    test_level_retrigger();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Prioritised interrupt controller placed between the interrupt sources (external pin, timer 0 done, timer 1 done) and the cpuy core.
- Latches requests, masks them with the global and per-source enables, and selects one winner by fixed priority.
- Presents one registered IRQ with its redirection vector and runs an IRQ / ACK / EOI handshake with the core.
- Returns per-source acknowledge pulses so the timers can clear their done flags. No nesting: one interrupt is in service at a time.

Parameters:
- NUM_SRC, 3: number of interrupt sources. Index 0 has the highest priority (0 = ext, 1 = T0, 2 = T1).
- ADDR_W, 10: program-counter / vector width.
- VEC_BASE, 10'h010: vector of source 0.
- VEC_STRIDE, 10'h010: vector spacing. Vectors are 0x10, 0x20, 0x30.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- src_req  in  NUM_SRC  raw request per source; already synchronous to clk.
- src_edge  in  NUM_SRC  per-source mode: 1 = rising-edge latched, 0 = level.
- gie  in  1  global interrupt enable (cpu_cfg[7]).
- src_ie  in  NUM_SRC  per-source enable; bit i maps to cpu_cfg[6-i].
- irq  out  1  interrupt request to core.
- vector  out  ADDR_W  redirection address for the current winner.
- irq_ack  in  1  one-cycle pulse; core has pushed PC and is redirecting.
- eoi  in  1  one-cycle pulse; core has executed return-from-interrupt.
- src_ack  out  NUM_SRC  one-cycle acknowledge pulse to the serviced source.
- in_service  out  1  a handler is running.
- pending  out  NUM_SRC  current pending vector, for debug and status reads.

Behaviour:
- Reset (asynchronous): state IDLE, irq=0, src_ack=0, in_service=0, pending=0, cur_src=0, vector=VEC_BASE, edge history=0.
- Pending bits:
  - Edge sources: bit i sets when src_req[i]=1 and prev[i]=0. prev is src_req delayed one cycle.
  - Level sources: pending[i] = src_req[i] as a registered copy.
  - An edge pending bit clears only on irq_ack while cur_src=i.
  - If a new edge arrives on the clearing cycle, set wins and the bit stays pending.
- Eligible = pending & src_ie, qualified by gie. Winner is the lowest set index; a priority encoder gives winner index and valid.
- State IDLE:
  - If gie and any eligible bit: cur_src <= winner, vector <= VEC_BASE + winner*VEC_STRIDE, irq <= 1, go REQUEST.
  - irq is registered, so it is visible 1 cycle after eligibility. 2 cycles after a raw edge on src_req.
- State REQUEST:
  - irq held high and vector held stable.
  - On irq_ack: irq <= 0, src_ack[cur_src] <= 1 for exactly one cycle, clear pending[cur_src] if edge mode, in_service <= 1, go SERVICE.
  - If gie falls, or src_ie[cur_src] falls, before ack: irq <= 0, go IDLE (request withdrawn), pending kept.
  - A higher-priority source arriving during REQUEST does not pre-empt; the winner is locked once irq is raised.
  - irq_ack and a withdrawal condition in the same cycle: ack wins.
- State SERVICE:
  - irq stays 0. New requests only accumulate in pending.
  - On eoi: in_service <= 0, go IDLE. Re-arbitration happens in the following cycle, so the next irq appears 2 cycles after eoi.
- Spurious pulses: eoi outside SERVICE and irq_ack outside REQUEST are ignored. They cause no state change and no src_ack.
- Level source still high after EOI: it re-triggers (intended for timer done held until acked).
- Width rule: the vector arithmetic is ADDR_W bits and wraps modulo 2^ADDR_W; no saturation.
- Reset mid-operation: returns immediately to reset values and drops any in-flight request or in-service status.

Decomposition:
- Shared package cpuy_pkg: state enum (IDLE, REQUEST, SERVICE), source index constants (SRC_EXT=0, SRC_T0=1, SRC_T1=2), default vector constants.
- Sub-module int_prio_enc: combinational fixed-priority encoder, NUM_SRC-bit input → index + valid. It is the natural reuse point for future arbiters.

Test Plan:
1. Reset values: assert rst mid-REQUEST → irq=0, in_service=0, pending=0, vector=0x010, all asynchronously with no clk edge required.
2. Single edge on ext: gie=1, src_ie=3'b001, src_edge=1, pulse src_req[0] 1 cycle → irq=1 two cycles later, vector=0x010. irq_ack → src_ack=3'b001 for 1 cycle, in_service=1, pending[0]=0.
3. Simultaneous requests: src_req[2:1] rise together with all enabled → vector=0x020 (T0 first). After ack and eoi, irq rises again 2 cycles after eoi with vector=0x030.
4. No nesting or pre-emption: T1 in SERVICE, ext edge arrives → irq stays 0, pending[0]=1. After eoi → irq, vector=0x010.
5. Withdrawal: REQUEST for T0, drop gie before ack → irq falls next cycle, state IDLE, pending[1] retained. Re-raise gie → irq returns with vector=0x020.
6. Edge set/clear collision and spurious pulses: new edge on src 0 in the same cycle as its irq_ack → pending[0] stays 1. eoi in IDLE and irq_ack in SERVICE → no effect.
